booth_mul_seq: RTL

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_op_fifo.sv | 49 ++++
 rtl/booth_mul_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared constants and FSM state type for the sequential Booth multiplier front-end.
package booth_pkg;

    localparam int OP_W            = 4;
    localparam int PROD_W          = 8;
    localparam int WAIT_CNT_W      = 4;
    localparam int DEFAULT_TIMEOUT = 12;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

endpackage

// File: rtl/booth_op_fifo.sv
// Operand FIFO holding {x,y} pairs; pointers carry one extra wrap bit to tell full from empty.
module booth_op_fifo
    import booth_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2 * OP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // NOTE: storage has no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/booth_mul_seq.sv
// Sequencer feeding queued operand pairs to a multi-cycle Booth core, one operation in flight,
// with a one-entry result slot and a sticky watchdog on the core's result strobe.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OP_W-1:0]               in_x,
    input  logic [OP_W-1:0]               in_y,
    output logic                          mul_start,
    output logic [OP_W-1:0]               mul_x,
    output logic [OP_W-1:0]               mul_y,
    input  logic                          mul_valid,
    input  logic [PROD_W-1:0]             mul_z,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PROD_W-1:0]             out_z,
    output logic                          err_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    state_t                 state_q;
    state_t                 state_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt;
    logic [OP_W-1:0]        hold_x;
    logic [OP_W-1:0]        hold_y;
    logic [2*OP_W-1:0]      fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   issue_go;
    logic                   capture;
    logic                   abort;
    logic                   slot_free;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    booth_op_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * OP_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (issue_go),
        .wr_data ({in_x, in_y}),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign slot_free = !out_valid || out_ready;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        issue_go = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    state_d  = ISSUE;
                    issue_go = 1'b1;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mul_valid) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (wait_cnt == WAIT_CNT_W'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (state_q == WAIT && state_d == WAIT) ? wait_cnt + 1'b1 : '0;
        end
    end

    // Operands are popped into the hold register on the way into ISSUE, so the core
    // sees the same bits from the start pulse until the result or abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_x <= '0;
            hold_y <= '0;
        end else if (issue_go) begin
            hold_x <= fifo_head[2*OP_W-1:OP_W];
            hold_y <= fifo_head[OP_W-1:0];
        end
    end

    assign mul_x     = hold_x;
    assign mul_y     = hold_y;
    assign mul_start = (state_q == ISSUE);

    // The core clears z right after its strobe, so the product is registered on the strobe itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_z       <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (capture) begin
                out_valid <= 1'b1;
                out_z     <= mul_z;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (abort)
                err_timeout <= 1'b1;
        end
    end

endmodule
